// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if -- sideband bundle between the pipeline and its hazard controller.
//   Inputs to the controller: ID source registers and use flags, EX/MEM/WB
//   destinations and write enables, EX load flag, redirect, rom_ready.
//   Outputs from the controller: rom_ce, pc_stall, if_id_stall, if_id_flush,
//   id_ex_flush, fetch_timeout, stall_cnt[CNT_W-1:0], state[1:0], plus
//   fwd_sel_a/fwd_sel_b when PIPE_HAZARD_CTRL_FWD_EN is defined.
//   slave  : controller side.  master : pipeline / driver side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_raddr1;
  logic [4:0]       id_raddr2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_waddr;
  logic             ex_reg_wr;
  logic             ex_is_load;
  logic [4:0]       mem_waddr;
  logic             mem_reg_wr;
  logic [4:0]       wb_waddr;
  logic             wb_reg_wr;
  logic             redirect;
  logic             rom_ready;

  logic             rom_ce;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             fetch_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;
`ifdef PIPE_HAZARD_CTRL_FWD_EN
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
`endif

  modport slave (
    input  id_raddr1, id_raddr2, id_rs1_used, id_rs2_used,
    input  ex_waddr, ex_reg_wr, ex_is_load, mem_waddr, mem_reg_wr,
    input  wb_waddr, wb_reg_wr, redirect, rom_ready,
    output rom_ce, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    output fetch_timeout, stall_cnt, state
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    , output fwd_sel_a, fwd_sel_b
`endif
  );

  modport master (
    output id_raddr1, id_raddr2, id_rs1_used, id_rs2_used,
    output ex_waddr, ex_reg_wr, ex_is_load, mem_waddr, mem_reg_wr,
    output wb_waddr, wb_reg_wr, redirect, rom_ready,
    input  rom_ce, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    input  fetch_timeout, stall_cnt, state
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    , input fwd_sel_a, fwd_sel_b
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- stall/flush sequencing for the 5-stage MIPS32 pipeline.
//   clk       : system clock
//   rst       : asynchronous, active-low reset
//   bus       : pipe_hazard_ctrl_if.slave (hazard inputs, fetch status, controls)
// Detects RAW hazards between ID sources and EX/MEM/WB destinations, holds the
// front end during instruction-ROM wait states, flushes after redirects and
// counts stalled cycles (saturating).
// Optional macro PIPE_HAZARD_CTRL_FWD_EN: adds forwarding selects and reduces
// the hazard to EX load-use only.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_WAIT     = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FWAIT = 2'd2,
    REDIR = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  localparam bit         REDIR_EN   = (FLUSH_CYCLES > 0);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic             fetch_timeout_q, fetch_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             wait_tick;

  logic rom_ce, pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic hit1, hit2, hazard;

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  // Youngest producer wins; $0 always reads the register file.
  function automatic logic [1:0] fwd_pick(
    input logic [4:0] r,
    input logic ex_wr,  input logic [4:0] ex_a,
    input logic mem_wr, input logic [4:0] mem_a,
    input logic wb_wr,  input logic [4:0] wb_a
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (r != 5'd0) begin
      if (ex_wr && ex_a == r)        sel = 2'd1;
      else if (mem_wr && mem_a == r) sel = 2'd2;
      else if (wb_wr && wb_a == r)   sel = 2'd3;
    end
    return sel;
  endfunction

  assign bus.fwd_sel_a = fwd_pick(bus.id_raddr1, bus.ex_reg_wr, bus.ex_waddr,
                                  bus.mem_reg_wr, bus.mem_waddr, bus.wb_reg_wr, bus.wb_waddr);
  assign bus.fwd_sel_b = fwd_pick(bus.id_raddr2, bus.ex_reg_wr, bus.ex_waddr,
                                  bus.mem_reg_wr, bus.mem_waddr, bus.wb_reg_wr, bus.wb_waddr);

  // Only a load in EX cannot be forwarded in time.
  assign hit1 = bus.id_rs1_used && (bus.id_raddr1 != 5'd0) && bus.ex_is_load &&
                bus.ex_reg_wr && (bus.ex_waddr == bus.id_raddr1);
  assign hit2 = bus.id_rs2_used && (bus.id_raddr2 != 5'd0) && bus.ex_is_load &&
                bus.ex_reg_wr && (bus.ex_waddr == bus.id_raddr2);
`else
  logic unused_is_load;
  assign unused_is_load = bus.ex_is_load;

  assign hit1 = bus.id_rs1_used && (bus.id_raddr1 != 5'd0) &&
                ((bus.ex_reg_wr  && bus.ex_waddr  == bus.id_raddr1) ||
                 (bus.mem_reg_wr && bus.mem_waddr == bus.id_raddr1) ||
                 (bus.wb_reg_wr  && bus.wb_waddr  == bus.id_raddr1));
  assign hit2 = bus.id_rs2_used && (bus.id_raddr2 != 5'd0) &&
                ((bus.ex_reg_wr  && bus.ex_waddr  == bus.id_raddr2) ||
                 (bus.mem_reg_wr && bus.mem_waddr == bus.id_raddr2) ||
                 (bus.wb_reg_wr  && bus.wb_waddr  == bus.id_raddr2));
`endif
  assign hazard = hit1 | hit2;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    redir_pend_d = redir_pend_q;
    wait_tick    = 1'b0;
    rom_ce       = 1'b1;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;

    case (state_q)
      BOOT: begin
        rom_ce   = 1'b0;
        pc_stall = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (bus.redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (REDIR_EN) begin
            state_d     = REDIR;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (!bus.rom_ready) begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          state_d     = FWAIT;
          wait_cnt_d  = 8'd1;
          wait_tick   = 1'b1;
        end else if (hazard) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      FWAIT: begin
        // The cycle rom_ready returns lets the fetch through; ID still holds
        // the NOP inserted during the wait, so no hazard check is needed.
        if (bus.rom_ready) begin
          state_d      = RUN;
          redir_pend_d = 1'b0;
          if (bus.redirect || redir_pend_q) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (REDIR_EN) begin
              state_d     = REDIR;
              flush_cnt_d = FLUSH_INIT;
            end
          end
        end else begin
          pc_stall     = 1'b1;
          if_id_flush  = 1'b1;
          redir_pend_d = redir_pend_q | bus.redirect;
          wait_cnt_d   = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
          wait_tick    = 1'b1;
        end
      end
      REDIR: begin
        if_id_flush = 1'b1;
        if (bus.redirect) begin
          id_ex_flush = 1'b1;
          flush_cnt_d = FLUSH_INIT;
        end else if (flush_cnt_q <= 3'd1) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: state_d = BOOT;
    endcase

    fetch_timeout_d = fetch_timeout_q | (wait_tick && (wait_cnt_d == WAIT_LIMIT));

    // Controls read as idle while reset is held, independent of the clock.
    if (!rst) begin
      rom_ce      = 1'b0;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end

    stall_cnt_d = (pc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= BOOT;
      wait_cnt_q      <= '0;
      flush_cnt_q     <= '0;
      redir_pend_q    <= 1'b0;
      fetch_timeout_q <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      redir_pend_q    <= redir_pend_d;
      fetch_timeout_q <= fetch_timeout_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign bus.rom_ce        = rom_ce;
  assign bus.pc_stall      = pc_stall;
  assign bus.if_id_stall   = if_id_stall;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.fetch_timeout = fetch_timeout_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.state         = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage MIPS32 core (pc → if_id → id_ex → ex_mem → mem_wb).
- Detects RAW hazards between the ID source registers and the EX/MEM/WB destinations.
- Handles instruction-ROM wait states and control-flow redirects.
- Drives the stall/flush controls of pc, if_id and id_ex, plus rom_ce.
- Keeps a saturating stall-cycle performance counter.

Parameters:
FLUSH_CYCLES, 1, extra cycles if_id_flush stays high after a redirect (1..7)
MAX_WAIT, 255, ROM wait cycles before fetch_timeout is set (8-bit compare)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
id_raddr1  in  5  ID source register 1
id_raddr2  in  5  ID source register 2
id_rs1_used  in  1  ID instruction reads raddr1
id_rs2_used  in  1  ID instruction reads raddr2
ex_waddr  in  5  EX destination
ex_reg_wr  in  1  EX writes regfile
ex_is_load  in  1  EX instruction is a load
mem_waddr  in  5  MEM destination
mem_reg_wr  in  1  MEM writes regfile
wb_waddr  in  5  WB destination
wb_reg_wr  in  1  WB writes regfile
redirect  in  1  branch/jump taken, pc loads target this cycle
rom_ready  in  1  instruction ROM data valid this cycle
rom_ce  out  1  instruction ROM enable
pc_stall  out  1  hold pc
if_id_stall  out  1  hold if_id
if_id_flush  out  1  load NOP into if_id
id_ex_flush  out  1  load bubble into id_ex (reg_wr=0, mem_wr=0)
fetch_timeout  out  1  sticky; ROM wait exceeded MAX_WAIT
stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1
state  out  2  FSM state (debug)

Behaviour:
- Reset (rst=0, async): state=BOOT, rom_ce=0, all stall/flush=0, fetch_timeout=0, stall_cnt=0, wait/flush counters=0.
- FSM states: BOOT=0, RUN=1, FWAIT=2, REDIR=3.
- BOOT: one cycle after reset release; rom_ce=0, pc_stall=1. Then RUN.
- rom_ce=1 in RUN, FWAIT and REDIR.
- Hazard term (combinational), per source s in {1,2}: hit_s = rs_s_used & raddr_s!=0 & (any stage X in EX/MEM/WB with X_reg_wr & X_waddr==raddr_s). hazard = hit1 | hit2. $0 never hazards.
- Priority in RUN, evaluated same cycle, outputs combinational from state and inputs:
  1. redirect=1: if_id_flush=1, id_ex_flush=1, pc_stall=0. If FLUSH_CYCLES>0, go to REDIR with flush counter=FLUSH_CYCLES. Redirect overrides any hazard in the same cycle.
  2. rom_ready=0: pc_stall=1, if_id_flush=1, id_ex/EX onward keep flowing. Go to FWAIT with wait counter=1.
  3. hazard=1: pc_stall=1, if_id_stall=1, id_ex_flush=1. Stay in RUN; resolves once the producer leaves WB (max 3 cycles).
  4. Otherwise all controls 0.
- FWAIT: pc_stall=1, if_id_flush=1. Wait counter increments and saturates at 255. When the counter reaches MAX_WAIT, set fetch_timeout (cleared only by reset). rom_ready=1 → RUN on the next cycle. redirect in FWAIT is latched and acted on as in RUN once rom_ready=1.
- REDIR: if_id_flush=1, pc_stall=0, hazard ignored (ID holds a NOP). Counter decrements; at 1 → RUN. A new redirect reloads the counter.
- stall_cnt: +1 on every clk with pc_stall=1, saturates at 2^CNT_W-1, no wrap.
- Simultaneous if_id_stall and if_id_flush never both asserted; flush wins.

Optional Feature:
PIPE_HAZARD_CTRL_FWD_EN
- Defined: adds outputs fwd_sel_a[1:0] and fwd_sel_b[1:0] (0=regfile, 1=EX result, 2=MEM result, 3=WB result; youngest match wins). hazard reduces to load-use only: ex_is_load & ex_reg_wr & ex_waddr matches a used nonzero source. Load-use is a 1-cycle stall.
- Undefined: no fwd_sel ports; full EX/MEM/WB RAW stall as above.

Test Plan:
- rst low then released → cycle 0 state=BOOT, rom_ce=0; cycle 1 state=RUN, rom_ce=1; stall_cnt=1.
- ex_reg_wr=1, ex_waddr=5, id_raddr1=5, rs1_used=1, pipeline advancing → pc_stall high 3 cycles (no FWD_EN) or 0 cycles with fwd_sel_a=1 (FWD_EN); stall_cnt +3.
- Same as previous but raddr1=0 → no stall.
- rom_ready low 4 cycles, MAX_WAIT=3 → pc_stall and if_id_flush high 4 cycles, fetch_timeout=1 and stays 1 after recovery.
- redirect=1 with a concurrent hazard, FLUSH_CYCLES=2 → cycle 0 pc_stall=0, both flushes=1; if_id_flush high 2 further cycles; then RUN.
- Assert rst mid-FWAIT → outputs immediately at reset values, stall_cnt=0, fetch_timeout=0.
